// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and address helpers for the Kyber NTT layer sequencer.
package ntt_pkg;

  localparam int unsigned N       = 256;
  localparam int unsigned LAYERS  = 7;
  localparam int unsigned Q       = 3329;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TW_W    = 7;
  localparam int unsigned BFLY_W  = 7;
  localparam int unsigned LAYER_W = 3;
  localparam int unsigned SHIFT_W = 4;

  localparam logic [BFLY_W-1:0]  BFLY_LAST  = BFLY_W'(N / 2 - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(LAYERS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // log2(len): forward len = 128 >> l, inverse len = 2 << l
  function automatic logic [SHIFT_W-1:0] fwd_shift(input logic [LAYER_W-1:0] l);
    return SHIFT_W'(7) - SHIFT_W'(l);
  endfunction

  function automatic logic [SHIFT_W-1:0] inv_shift(input logic [LAYER_W-1:0] l);
    return SHIFT_W'(l) + SHIFT_W'(1);
  endfunction

  // Operand j: group index scaled by 2*len, plus offset inside the group
  function automatic logic [ADDR_W-1:0] calc_addr_a(input logic [BFLY_W-1:0] b,
                                                    input logic [SHIFT_W-1:0] s);
    logic [ADDR_W-1:0] bw;
    logic [ADDR_W-1:0] mask;
    bw   = ADDR_W'(b);
    mask = (ADDR_W'(1) << s) - ADDR_W'(1);
    return ((bw >> s) << (s + SHIFT_W'(1))) | (bw & mask);
  endfunction

  function automatic logic [TW_W-1:0] fwd_tw(input logic [LAYER_W-1:0] l,
                                             input logic [BFLY_W-1:0] b,
                                             input logic [SHIFT_W-1:0] s);
    logic [ADDR_W-1:0] g;
    g = ADDR_W'(b) >> s;
    return TW_W'((ADDR_W'(1) << l) + g);
  endfunction

  function automatic logic [TW_W-1:0] inv_tw(input logic [LAYER_W-1:0] l,
                                             input logic [BFLY_W-1:0] b,
                                             input logic [SHIFT_W-1:0] s);
    logic [ADDR_W-1:0] g;
    g = ADDR_W'(b) >> s;
    return TW_W'((ADDR_W'(N / 2) >> l) - ADDR_W'(1) - g);
  endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// Shift register carrying {valid, addr_a, addr_b} so write-back addresses line up with butterfly results.
module ntt_addr_delay #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
  output logic          out_valid,
  output logic [AW-1:0] out_addr_a,
  output logic [AW-1:0] out_addr_b
);

  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    a_q [DEPTH];
  logic [AW-1:0]    b_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      a_q[0]   <= in_addr_a;
      b_q[0]   <= in_addr_b;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        a_q[i]   <= a_q[i-1];
        b_q[i]   <= b_q[i-1];
      end
    end
  end

  assign out_valid  = vld_q[DEPTH-1];
  assign out_addr_a = a_q[DEPTH-1];
  assign out_addr_b = b_q[DEPTH-1];

endmodule

// File: rtl/ntt_layer_sequencer.sv
// Walks the butterfly unit through 7 NTT layers, issuing reads and tracking in-place write-back.
// Inverse transform support is generated only when NTT_SEQ_INVERSE_EN is defined.
import ntt_pkg::*;

module ntt_layer_sequencer #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BF_LAT = 3
) (
  input  logic       clk,
  input  logic       r,
  input  logic       start,
  input  logic       inverse,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] tw_addr,
  output logic       bf_valid,
  output logic       bf_inverse,
  input  logic       bf_valid_out,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam int unsigned PIPE  = RD_LAT + BF_LAT;
  localparam int unsigned CNT_W = $clog2(PIPE + 2);

  state_t               state;
  logic [BFLY_W-1:0]    bfly, nxt_bfly;
  logic [LAYER_W-1:0]   layer, nxt_layer;
  logic [CNT_W-1:0]     in_flight, in_flight_nxt;
  logic                 drained, issue;
  logic [SHIFT_W-1:0]   nxt_s;
  logic [ADDR_W-1:0]    nxt_a, nxt_len;
  logic [TW_W-1:0]      nxt_tw;
  logic [RD_LAT-1:0]    rd_pipe;
  logic                 inv_q;
  logic                 dly_valid;
  logic [ADDR_W-1:0]    dly_a, dly_b;

  assign wr_en         = bf_valid_out & busy;
  assign in_flight_nxt = in_flight + CNT_W'(rd_en) - CNT_W'(wr_en);
  assign drained       = (in_flight_nxt == '0);
  assign bf_valid      = rd_pipe[RD_LAT-1];
  assign bf_inverse    = inv_q;

`ifdef NTT_SEQ_INVERSE_EN
  logic mode;

  // First issue must see the mode being accepted, not the previous one
  assign mode = (state == IDLE) ? inverse : inv_q;

  always_ff @(posedge clk or negedge r) begin
    if (!r)                          inv_q <= 1'b0;
    else if (state == IDLE && start) inv_q <= inverse;
  end
`else
  logic unused_inverse;
  assign unused_inverse = inverse;
  assign inv_q          = 1'b0;
`endif

  // Next butterfly to issue and its operand/twiddle addresses
  always_comb begin
    issue     = 1'b0;
    nxt_bfly  = bfly;
    nxt_layer = layer;
    unique case (state)
      IDLE:  if (start) begin
               issue     = 1'b1;
               nxt_bfly  = '0;
               nxt_layer = '0;
             end
      ISSUE: if (bfly != BFLY_LAST) begin
               issue    = 1'b1;
               nxt_bfly = bfly + BFLY_W'(1);
             end
      DRAIN: if (drained && layer != LAYER_LAST) begin
               issue     = 1'b1;
               nxt_bfly  = '0;
               nxt_layer = layer + LAYER_W'(1);
             end
      default: ;
    endcase
`ifdef NTT_SEQ_INVERSE_EN
    nxt_s  = mode ? inv_shift(nxt_layer) : fwd_shift(nxt_layer);
    nxt_tw = mode ? inv_tw(nxt_layer, nxt_bfly, nxt_s) : fwd_tw(nxt_layer, nxt_bfly, nxt_s);
`else
    nxt_s  = fwd_shift(nxt_layer);
    nxt_tw = fwd_tw(nxt_layer, nxt_bfly, nxt_s);
`endif
    nxt_a   = calc_addr_a(nxt_bfly, nxt_s);
    nxt_len = ADDR_W'(1) << nxt_s;
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state     <= IDLE;
      bfly      <= '0;
      layer     <= '0;
      in_flight <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      rd_pipe   <= '0;
    end else begin
      in_flight <= in_flight_nxt;
      done      <= 1'b0;
      rd_en     <= issue;
      rd_pipe[0] <= rd_en;
      for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
      if (issue) begin
        bfly      <= nxt_bfly;
        layer     <= nxt_layer;
        rd_addr_a <= nxt_a;
        rd_addr_b <= nxt_a + nxt_len;
        tw_addr   <= nxt_tw;
      end else begin
        rd_addr_a <= '0;
        rd_addr_b <= '0;
        tw_addr   <= '0;
      end
      unique case (state)
        IDLE:  if (start) begin
                 state <= ISSUE;
                 busy  <= 1'b1;
               end
        ISSUE: if (bfly == BFLY_LAST) state <= DRAIN;
        // Next layer reads only start once every write of this layer has landed
        DRAIN: if (drained) begin
                 if (layer == LAYER_LAST) begin
                   state <= DONE;
                   busy  <= 1'b0;
                   done  <= 1'b1;
                 end else begin
                   state <= ISSUE;
                 end
               end
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ntt_addr_delay #(.DEPTH(PIPE), .AW(ADDR_W)) u_addr_delay (
    .clk        (clk),
    .rst_n      (r),
    .in_valid   (rd_en),
    .in_addr_a  (rd_addr_a),
    .in_addr_b  (rd_addr_b),
    .out_valid  (dly_valid),
    .out_addr_a (dly_a),
    .out_addr_b (dly_b)
  );

  assign wr_addr_a = dly_valid ? dly_a : '0;
  assign wr_addr_b = dly_valid ? dly_b : '0;

endmodule

// File: tb/tb_ntt_layer_sequencer.sv
// Scoreboard bench for ntt_layer_sequencer: reference Kyber loop nest feeds expected issues,
// a negedge monitor checks reads, write-back alignment, timing and reset behaviour.
module tb_ntt_layer_sequencer;

  localparam int BF_LAT   = 3;
  localparam int DONE_CYC = 925;
  localparam int LAST_WR  = 924;

  logic       clk = 1'b0;
  logic       r, start, inverse;
  logic       busy, done, rd_en, bf_valid, bf_inverse, bf_valid_out, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] tw_addr;
  logic [BF_LAT-1:0] bfp = '0;

  typedef struct {int a; int b; int k;} iss_t;
  typedef struct {int a; int b; int cyc; int layer;} wr_t;
  typedef struct {int mode; int idx; int a; int b; int k;} dir_t;

  iss_t exp_rd[$];
  wr_t  exp_wr[$];
  dir_t dirs[10];

  int checks = 0, errors = 0;
  int edge_cnt = 0, t0 = 0, issue_idx = 0, exp_inv = 0;
  bit running = 0, done_seen = 0, prev_rd = 0;

  ntt_layer_sequencer dut (
    .clk(clk), .r(r), .start(start), .inverse(inverse), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bf_valid(bf_valid), .bf_inverse(bf_inverse), .bf_valid_out(bf_valid_out),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Butterfly stand-in: fixed latency, never cleared by the sequencer's reset
  always @(posedge clk) bfp <= {bfp[BF_LAT-2:0], bf_valid};
  assign bf_valid_out = bfp[BF_LAT-1];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void check_all_zero(string tag);
    chk({tag, "_busy"}, busy, 0);           chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);         chk({tag, "_rd_addr_a"}, rd_addr_a, 0);
    chk({tag, "_rd_addr_b"}, rd_addr_b, 0); chk({tag, "_tw_addr"}, tw_addr, 0);
    chk({tag, "_bf_valid"}, bf_valid, 0);   chk({tag, "_bf_inverse"}, bf_inverse, 0);
    chk({tag, "_wr_en"}, wr_en, 0);         chk({tag, "_wr_addr_a"}, wr_addr_a, 0);
    chk({tag, "_wr_addr_b"}, wr_addr_b, 0);
  endfunction

  // Reference Kyber ntt()/invntt() loop order
  task automatic build_expected(input int mode);
    int k;
    exp_rd.delete();
    exp_wr.delete();
    if (mode == 0) begin
      k = 1;
      for (int len = 128; len >= 2; len = len / 2)
        for (int st = 0; st < 256; st += 2 * len) begin
          for (int j = st; j < st + len; j++) exp_rd.push_back('{a: j, b: j + len, k: k});
          k++;
        end
    end else begin
      k = 127;
      for (int len = 2; len <= 128; len = len * 2)
        for (int st = 0; st < 256; st += 2 * len) begin
          for (int j = st; j < st + len; j++) exp_rd.push_back('{a: j, b: j + len, k: k});
          k--;
        end
    end
  endtask

  // Monitor: samples on the falling edge, cycle 1 = first cycle after the accepting edge
  always @(negedge clk) begin
    int cyc, lay;
    iss_t e;
    wr_t w;
    if (r && running) begin
      cyc = edge_cnt - t0 + 1;
      chk("busy", busy, (cyc >= 1 && cyc <= LAST_WR) ? 1 : 0);
      chk("bf_valid", bf_valid, prev_rd);
      prev_rd = rd_en;
      if (wr_en) begin
        chk("wr_expected", (exp_wr.size() > 0) ? 1 : 0, 1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk("wr_addr_a", wr_addr_a, w.a);
          chk("wr_addr_b", wr_addr_b, w.b);
          chk("wr_delay", cyc - w.cyc, 4);
        end
      end
      if (rd_en) begin
        chk("rd_expected", (exp_rd.size() > 0) ? 1 : 0, 1);
        if (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          lay = issue_idx / 128;
          chk("rd_addr_a", rd_addr_a, e.a);
          chk("rd_addr_b", rd_addr_b, e.b);
          chk("tw_addr", tw_addr, e.k);
          chk("bf_inverse", bf_inverse, exp_inv);
          chk("issue_cycle", cyc, 1 + lay * 132 + issue_idx % 128);
          for (int d = 0; d < 10; d++)
            if (dirs[d].mode == exp_inv && dirs[d].idx == issue_idx) begin
              chk($sformatf("vec%0d_a", issue_idx), rd_addr_a, dirs[d].a);
              chk($sformatf("vec%0d_b", issue_idx), rd_addr_b, dirs[d].b);
              chk($sformatf("vec%0d_k", issue_idx), tw_addr, dirs[d].k);
            end
          if (exp_wr.size() > 0) chk("raw_hazard_layer", exp_wr[0].layer, lay);
          exp_wr.push_back('{a: e.a, b: e.b, cyc: cyc, layer: lay});
          issue_idx++;
        end
      end
      if (done) begin
        chk("done_cycle", cyc, DONE_CYC);
        chk("done_rd_left", exp_rd.size(), 0);
        chk("done_wr_left", exp_wr.size(), 0);
        done_seen = 1;
        running = 0;
      end
    end else if (r) begin
      chk("idle_wr_en", wr_en, 0);
      chk("idle_rd_en", rd_en, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
  end

  task automatic begin_run(input int inv);
    int eff;
`ifdef NTT_SEQ_INVERSE_EN
    eff = inv;
`else
    eff = 0;
`endif
    build_expected(eff);
    exp_inv = eff; issue_idx = 0; prev_rd = 0; done_seen = 0;
    @(negedge clk);
    t0 = edge_cnt + 1; running = 1; start = 1; inverse = inv[0];
    @(negedge clk);
    start = 0; inverse = ~inv[0];
  endtask

  task automatic run_full(input int inv, input bit stray);
    begin_run(inv);
    if (stray) begin
      repeat (298) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < 1100 && !done_seen; i++) begin
      @(negedge clk);
      #1;
    end
    chk("done_seen", done_seen, 1);
    running = 0;
  endtask

  task automatic run_abort();
    begin_run(0);
    repeat (498) @(negedge clk);
    @(posedge clk);
    #2 r = 0; running = 0;
    #1 check_all_zero("mid_reset");
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    r = 1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    dirs[0] = '{0, 0, 0, 128, 1};     dirs[1] = '{0, 1, 1, 129, 1};
    dirs[2] = '{0, 2, 2, 130, 1};     dirs[3] = '{0, 127, 127, 255, 1};
    dirs[4] = '{0, 768, 0, 2, 64};    dirs[5] = '{0, 769, 1, 3, 64};
    dirs[6] = '{0, 770, 4, 6, 65};    dirs[7] = '{0, 895, 253, 255, 127};
    dirs[8] = '{1, 0, 0, 2, 127};     dirs[9] = '{1, 768, 0, 128, 1};
    r = 0; start = 0; inverse = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    r = 1;
    repeat (2) @(negedge clk);
    run_full(0, 1'b1);
    run_full(1, 1'b0);
    run_abort();
    run_full(1, 1'b0);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks %0d errors %0d)", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/ntt_layer_sequencer.md
# ntt_layer_sequencer

Control and address generator that drives the Kyber butterfly unit through a complete 256-point NTT or inverse NTT (7 layers × 128 butterflies, q = 3329). It issues coefficient-RAM reads, twiddle-ROM addresses and the butterfly `valid_in`/`inverse` controls. It tracks write-back addresses through the read and butterfly latency so that `U`/`V` results are written in place. It sits directly upstream of the butterfly and owns the coefficient RAM's address and write-enable ports.

## Interface
- `RD_LAT`, 1: coefficient RAM and twiddle ROM read latency, in cycles.
- `BF_LAT`, 3: butterfly latency from `valid_in` to `valid_out`, in both modes.
- `clk`  in  1  single clock; all logic is rising-edge.
- `r`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `inverse`  in  1  mode select (1 = iNTT); sampled when `start` is accepted.
- `busy`  out  1  high from the accepted start until `done`.
- `done`  out  1  one-cycle pulse after the final write-back.
- `rd_en`  out  1  read strobe for both RAM ports.
- `rd_addr_a`, `rd_addr_b`  out  8  addresses of butterfly operands j and j+len.
- `tw_addr`  out  7  twiddle-ROM index k.
- `bf_valid`  out  1  drives butterfly `valid_in`; equals `rd_en` delayed by `RD_LAT`.
- `bf_inverse`  out  1  latched mode bit, held stable for the whole transform.
- `bf_valid_out`  in  1  butterfly `valid_out`.
- `wr_en`  out  1  write strobe for both RAM ports; equals `bf_valid_out` while busy.
- `wr_addr_a`, `wr_addr_b`  out  8  write addresses for U and V.

## Operation
- **States**
  - IDLE: on `start`, latch `inverse`, clear counters, go to ISSUE.
  - ISSUE: one butterfly per cycle, with `rd_en` high. Butterfly counter b runs 0..127. After b = 127, go to DRAIN.
  - DRAIN: `rd_en` stays low until the in-flight count reaches 0, then either:
    - go to ISSUE with layer+1, or
    - after layer 6, go to DONE.
  - DONE: pulse `done` for one cycle, then go to IDLE.
- **Layer length**
  - Forward: len = 128 >> l.
  - Inverse: len = 2 << l.
  - l runs 0..6 in both modes.
- **Addresses**: with s = log2(len):
  - rd_addr_a = ((b >> s) << (s+1)) | (b & (len−1)).
  - rd_addr_b = rd_addr_a + len.
- **Twiddle index**: with g = b >> s:
  - Forward: tw_addr = (1 << l) + g.
  - Inverse: tw_addr = (128 >> l) − 1 − g.
- **Write-back addresses**
  - Each issued (a, b) pair enters a delay line of depth `RD_LAT`+`BF_LAT`.
  - `wr_addr_a`/`wr_addr_b` are the delay-line outputs aligned with `bf_valid_out`.
- **In-flight counter**: counts up on `rd_en`, down on `wr_en`. It never exceeds `RD_LAT`+`BF_LAT`+1.
- **Drain rule**: draining between layers is mandatory. A layer's reads must never overlap the previous layer's writes (RAW hazard).
- **No final scaling**: the butterfly halves every inverse result, so no n⁻¹ multiply is issued.
- **Ignored inputs**:
  - `start` while busy is ignored.
  - `inverse` changes after acceptance are ignored.
  - `bf_valid_out` while not busy produces no write.
- **Reset (`r` low), including mid-transform**:
  - State goes to IDLE.
  - All counters and the delay line clear.
  - All outputs go to 0.

## Timing
- Reset values: every output is 0.
- `start` accepted at cycle 0 → first `rd_en` at cycle 1.
- `bf_valid` at cycle 1+`RD_LAT`; first `wr_en` at cycle 1+`RD_LAT`+`BF_LAT`.
- Per layer: 128 issue cycles + (`RD_LAT`+`BF_LAT`) drain cycles. Defaults give 132 cycles per layer.
- Total with defaults:
  - Last `wr_en` at cycle 924.
  - `done` at cycle 925.
  - `busy` falls together with `done`.
  - Next `start` accepted at cycle 926.
- `rd_en` is never high in the same cycle as the first issue of the next layer while `wr_en` from the previous layer is still pending.

## Configuration
- `NTT_SEQ_INVERSE_EN` defined:
  - `inverse` is honoured.
  - The inverse layer order and twiddle indexing are generated.
- Undefined:
  - `inverse` is ignored and `bf_inverse` is tied to 0.
  - Forward-only logic is generated, with no inverse twiddle arithmetic.

## Structure
- Package `ntt_pkg` holds:
  - N = 256, LAYERS = 7, Q = 3329.
  - Address widths (8-bit coefficient, 7-bit twiddle).
  - The state enum (IDLE, ISSUE, DRAIN, DONE).
- Sub-module `ntt_addr_delay`: a parameterised shift register carrying {valid, addr_a, addr_b} with asynchronous active-low clear. Its depth is `RD_LAT`+`BF_LAT`.

## Test plan
- Forward start, layer 0 → first three issues are (0,128,k=1), (1,129,k=1), (2,130,k=1). The b = 127 issue is (127,255,k=1).
- Forward layer 6 (len 2) → issues (0,2,k=64), (1,3,k=64), (4,6,k=65). The last issue is (253,255,k=127).
- Inverse (`NTT_SEQ_INVERSE_EN` defined), layer 0 → first issue is (0,2,k=127). The final layer's first issue is (0,128,k=1).
- Butterfly model with `BF_LAT`=3 → `wr_addr` equals `rd_addr` delayed 4 cycles. No read occurs while the previous layer has writes pending. `done` occurs at cycle 925.
- `start` pulsed at cycle 300 while busy → no effect, and `done` still occurs at cycle 925.
- `r` asserted at cycle 500 → all outputs are 0 immediately. After release, a new `start` runs a full 925-cycle transform.
